// File: rtl/sram_async_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sram_async_ctrl
//  Brief    : Asynchronous cellular RAM controller. Converts a valid/ready
//             request port into CE/OE/WE strobe sequences with programmable
//             read/write wait states and bus turnaround, driving the data
//             bus through per-bit o/t pairs (t=1 means high-Z).
//  Revision : 1.0 - initial release
// ============================================================================
module sram_async_ctrl #(
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 8,
    parameter int RD_WAIT = 7,
    parameter int WR_WAIT = 6,
    parameter int TURN    = 1
) (
    input  logic              sys_clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    input  logic [DATA_W-1:0] ram_dq_i,
    output logic [DATA_W-1:0] ram_dq_o,
    output logic [DATA_W-1:0] ram_dq_t
);

    // Wait counter sized for the longest programmable phase.
    localparam int c_max_wait = (RD_WAIT > WR_WAIT) ?
                                ((RD_WAIT > TURN) ? RD_WAIT : TURN) :
                                ((WR_WAIT > TURN) ? WR_WAIT : TURN);
    localparam int c_cnt_w = $clog2(c_max_wait + 1);

    localparam logic [c_cnt_w-1:0] c_rd_load   = c_cnt_w'(RD_WAIT - 1);
    localparam logic [c_cnt_w-1:0] c_wr_load   = c_cnt_w'(WR_WAIT - 1);
    localparam logic [c_cnt_w-1:0] c_turn_load = c_cnt_w'((TURN > 0) ? (TURN - 1) : 0);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_rd      = 3'd1;
    localparam logic [2:0] c_st_wr      = 3'd2;
    localparam logic [2:0] c_st_wr_hold = 3'd3;
    localparam logic [2:0] c_st_turn    = 3'd4;

    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic               r_rsp_we;
    logic [DATA_W-1:0]  r_rsp_rdata;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic               r_ram_ce_n;
    logic               r_ram_oe_n;
    logic               r_ram_we_n;
    logic [DATA_W-1:0]  r_ram_dq_o;
    logic [DATA_W-1:0]  r_ram_dq_t;

    // Access sequencer: every pin and response output is a register of this FSM.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_we    <= 1'b0;
            r_rsp_rdata <= '0;
            r_ram_addr  <= '0;
            r_ram_ce_n  <= 1'b1;
            r_ram_oe_n  <= 1'b1;
            r_ram_we_n  <= 1'b1;
            r_ram_dq_o  <= '0;
            r_ram_dq_t  <= '1;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_ram_addr  <= req_addr;
                        r_ram_ce_n  <= 1'b0;
                        if (req_we) begin
                            r_state    <= c_st_wr;
                            r_cnt      <= c_wr_load;
                            r_ram_we_n <= 1'b0;
                            r_ram_dq_o <= req_wdata;
                            r_ram_dq_t <= '0;
                        end else begin
                            r_state    <= c_st_rd;
                            r_cnt      <= c_rd_load;
                            r_ram_oe_n <= 1'b0;
                        end
                    end
                end
                c_st_rd: begin
                    if (r_cnt == '0) begin
                        // Data is sampled at the end of the last OE-low cycle.
                        r_rsp_rdata <= ram_dq_i;
                        r_rsp_valid <= 1'b1;
                        r_rsp_we    <= 1'b0;
                        r_ram_ce_n  <= 1'b1;
                        r_ram_oe_n  <= 1'b1;
                        if (TURN == 0) begin
                            r_state     <= c_st_idle;
                            r_req_ready <= 1'b1;
                        end else begin
                            r_state <= c_st_turn;
                            r_cnt   <= c_turn_load;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                c_st_wr: begin
                    if (r_cnt == '0) begin
                        // Release WE but keep CE and the bus for one hold cycle.
                        r_ram_we_n <= 1'b1;
                        r_state    <= c_st_wr_hold;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                c_st_wr_hold: begin
                    r_ram_ce_n  <= 1'b1;
                    r_ram_dq_t  <= '1;
                    r_rsp_valid <= 1'b1;
                    r_rsp_we    <= 1'b1;
                    if (TURN == 0) begin
                        r_state     <= c_st_idle;
                        r_req_ready <= 1'b1;
                    end else begin
                        r_state <= c_st_turn;
                        r_cnt   <= c_turn_load;
                    end
                end
                c_st_turn: begin
                    if (r_cnt == '0) begin
                        r_state     <= c_st_idle;
                        r_req_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_req_ready <= 1'b1;
                    r_ram_ce_n  <= 1'b1;
                    r_ram_oe_n  <= 1'b1;
                    r_ram_we_n  <= 1'b1;
                    r_ram_dq_t  <= '1;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_we    = r_rsp_we;
    assign rsp_rdata = r_rsp_rdata;
    assign ram_addr  = r_ram_addr;
    assign ram_ce_n  = r_ram_ce_n;
    assign ram_oe_n  = r_ram_oe_n;
    assign ram_we_n  = r_ram_we_n;
    assign ram_dq_o  = r_ram_dq_o;
    assign ram_dq_t  = r_ram_dq_t;

endmodule
`default_nettype wire

// File: tb/tb_sram_async_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_async_ctrl
//  Brief    : Directed bench for sram_async_ctrl: default build (RD_WAIT=7,
//             WR_WAIT=6, TURN=1) against a RAM model, plus a TURN=0/RD_WAIT=1
//             build for back-to-back reads.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_async_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Default build
    logic        req_valid, req_ready, req_we, rsp_valid, rsp_we;
    logic [18:0] req_addr, ram_addr;
    logic [7:0]  req_wdata, rsp_rdata, dq_i, dq_o, dq_t;
    logic        ce_n, oe_n, we_n;

    // TURN=0, RD_WAIT=1 build
    logic        req_valid2, req_ready2, req_we2, rsp_valid2, rsp_we2;
    logic [18:0] req_addr2, ram_addr2;
    logic [7:0]  req_wdata2, rsp_rdata2, dq_i2, dq_o2, dq_t2;
    logic        ce_n2, oe_n2, we_n2;

    sram_async_ctrl dut (
        .sys_clock(clk), .reset(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
        .ram_addr(ram_addr), .ram_ce_n(ce_n), .ram_oe_n(oe_n), .ram_we_n(we_n),
        .ram_dq_i(dq_i), .ram_dq_o(dq_o), .ram_dq_t(dq_t)
    );

    sram_async_ctrl #(.RD_WAIT(1), .TURN(0)) dut2 (
        .sys_clock(clk), .reset(rst),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2),
        .req_addr(req_addr2), .req_wdata(req_wdata2),
        .rsp_valid(rsp_valid2), .rsp_we(rsp_we2), .rsp_rdata(rsp_rdata2),
        .ram_addr(ram_addr2), .ram_ce_n(ce_n2), .ram_oe_n(oe_n2), .ram_we_n(we_n2),
        .ram_dq_i(dq_i2), .ram_dq_o(dq_o2), .ram_dq_t(dq_t2)
    );

    // RAM model for the default build
    logic [7:0] mem [0:(1<<19)-1];
    assign dq_i = (!ce_n && !oe_n) ? mem[ram_addr] : 8'h00;
    always @(posedge clk) begin
        if (!rst && !ce_n && !we_n) mem[ram_addr] <= dq_o;
    end

    // Second build returns an address-derived pattern
    assign dq_i2 = (!ce_n2 && !oe_n2) ? (ram_addr2[7:0] ^ 8'h5A) : 8'h00;

    int n_err = 0;
    int n_chk = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitors
    int viol = 0;
    int we_run = 0;
    int we_runs[$];
    int rsp_cnt = 0;
    logic [7:0] rd2_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (!oe_n && dq_t != 8'hFF) viol++;
            if (!oe_n && !we_n) viol++;
            if (!oe_n2 && dq_t2 != 8'hFF) viol++;
            if (!oe_n2 && !we_n2) viol++;
            if (rsp_valid) rsp_cnt++;
            if (rsp_valid2) rd2_q.push_back(rsp_rdata2);
        end
        if (!we_n) we_run++;
        else if (we_run != 0) begin
            we_runs.push_back(we_run);
            we_run = 0;
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        check_eq("ready_wait", {31'd0, req_ready}, 32'd1);
    endtask

    // Single access on the default build; starts at a negedge with ready high.
    task automatic do_access(input logic we, input logic [18:0] a, input logic [7:0] d,
                             output int lat, output int we_low, output int oe_low,
                             output logic [18:0] a_seen, output logic [7:0] t_seen,
                             output logic rdy1, output logic [7:0] rd, output logic rwe);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        lat = 0; we_low = 0; oe_low = 0; a_seen = '0; t_seen = '0; rdy1 = 1'b1;
        rd = '0; rwe = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                req_valid = 1'b0;
                a_seen = ram_addr; t_seen = dq_t; rdy1 = req_ready;
            end
            if (!we_n) we_low++;
            if (!oe_n) oe_low++;
            if (rsp_valid) begin
                rd = rsp_rdata; rwe = rsp_we;
                break;
            end
        end
    endtask

    int lat, wl, ol, k, rc0;
    logic [18:0] as;
    logic [7:0] ts, rd;
    logic r1, rw;

    initial begin
        rst = 1'b1;
        req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
        req_valid2 = 0; req_we2 = 0; req_addr2 = '0; req_wdata2 = '0;
        mem[19'h7FFFF] = 8'h3C;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_rsp_we", {31'd0, rsp_we}, 32'd0);
        check_eq("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
        check_eq("rst_strobes", {29'd0, ce_n, oe_n, we_n}, 32'd7);
        check_eq("rst_dq_t", {24'd0, dq_t}, 32'hFF);
        check_eq("rst_dq_o", {24'd0, dq_o}, 32'd0);
        check_eq("rst_addr", {13'd0, ram_addr}, 32'd0);
        check_eq("rst_ready2", {31'd0, req_ready2}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Write 0xA5 @0x10
        do_access(1'b1, 19'h00010, 8'hA5, lat, wl, ol, as, ts, r1, rd, rw);
        check_eq("wr_latency", lat, 32'd8);
        check_eq("wr_we_low", wl, 32'd6);
        check_eq("wr_oe_low", ol, 32'd0);
        check_eq("wr_addr", {13'd0, as}, 32'h10);
        check_eq("wr_dq_t", {24'd0, ts}, 32'h00);
        check_eq("wr_ready_drop", {31'd0, r1}, 32'd0);
        check_eq("wr_rsp_we", {31'd0, rw}, 32'd1);
        check_eq("wr_mem", {24'd0, mem[19'h10]}, 32'hA5);
        wait_ready();

        // Read it back
        do_access(1'b0, 19'h00010, 8'h00, lat, wl, ol, as, ts, r1, rd, rw);
        check_eq("rd_latency", lat, 32'd8);
        check_eq("rd_oe_low", ol, 32'd7);
        check_eq("rd_we_low", wl, 32'd0);
        check_eq("rd_dq_t", {24'd0, ts}, 32'hFF);
        check_eq("rd_data", {24'd0, rd}, 32'hA5);
        check_eq("rd_rsp_we", {31'd0, rw}, 32'd0);
        wait_ready();

        // Max address read
        do_access(1'b0, 19'h7FFFF, 8'h00, lat, wl, ol, as, ts, r1, rd, rw);
        check_eq("max_addr", {13'd0, as}, 32'h7FFFF);
        check_eq("max_data", {24'd0, rd}, 32'h3C);
        check_eq("max_latency", lat, 32'd8);
        wait_ready();

        // Back-to-back writes with req_valid held high
        we_runs.delete();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 19'h20; req_wdata = 8'h11;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            k++;
            if (k == 1) begin req_addr = 19'h21; req_wdata = 8'h22; end
            if (req_ready) break;
        end
        check_eq("b2b_spacing", k, 32'd9);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("b2b_runs", we_runs.size(), 32'd2);
        if (we_runs.size() == 2) begin
            check_eq("b2b_run0", we_runs[0], 32'd6);
            check_eq("b2b_run1", we_runs[1], 32'd6);
        end
        check_eq("b2b_mem0", {24'd0, mem[19'h20]}, 32'h11);
        check_eq("b2b_mem1", {24'd0, mem[19'h21]}, 32'h22);
        wait_ready();

        // Request while busy: write queued behind a read is held off until IDLE
        rc0 = rsp_cnt;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 19'h10;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                check_eq("busy_ready_low", {31'd0, req_ready}, 32'd0);
                req_we = 1'b1; req_addr = 19'h30; req_wdata = 8'h77;
            end
            if (req_ready) break;
        end
        check_eq("busy_accept_gap", k, 32'd9);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("busy_rsp_count", rsp_cnt - rc0, 32'd2);
        check_eq("busy_mem", {24'd0, mem[19'h30]}, 32'h77);
        wait_ready();

        // Reset during WR cycle 3
        req_valid = 1'b1; req_we = 1'b1; req_addr = 19'h40; req_wdata = 8'h99;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_mid_we_low", {31'd0, we_n}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_strobes", {30'd0, ce_n, we_n}, 32'd3);
        check_eq("rst_mid_dq_t", {24'd0, dq_t}, 32'hFF);
        check_eq("rst_mid_rsp", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b0;
        rc0 = rsp_cnt;
        repeat (12) @(negedge clk);
        check_eq("rst_mid_no_rsp", rsp_cnt - rc0, 32'd0);

        // TURN=0, RD_WAIT=1 build: back-to-back reads
        rd2_q.delete();
        req_valid2 = 1'b1; req_we2 = 1'b0; req_addr2 = 19'h3;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                check_eq("t0_ready_low", {31'd0, req_ready2}, 32'd0);
                req_addr2 = 19'h4;
            end
            if (req_ready2) break;
        end
        check_eq("t0_spacing", k, 32'd2);
        @(negedge clk);
        req_valid2 = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("t0_rsp_count", rd2_q.size(), 32'd2);
        if (rd2_q.size() == 2) begin
            check_eq("t0_rdata0", {24'd0, rd2_q[0]}, 32'h59);
            check_eq("t0_rdata1", {24'd0, rd2_q[1]}, 32'h5E);
        end

        check_eq("bus_oe_we_excl", viol, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
